// File: rtl/add_i8v4_arbiter_pkg.sv
// Shared types and constants for the two-requester i8x4 lane-wise adder.
// Defines the lane geometry, the result-slot state and the requester id type.
package add_i8v4_arbiter_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int DATA_W = LANES * LANE_W;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    typedef logic req_id_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/add_i8v4_arbiter_lanes.sv
// Combinational 4 x i8 lane adder; each lane wraps mod 256 with no carry
// crossing into its neighbour.
module add_i8v4_lanes
    import add_i8v4_arbiter_pkg::*;
(
    input  word_t a_i,
    input  word_t b_i,
    output word_t y_o
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign y_o[gi*LANE_W +: LANE_W] = a_i[gi*LANE_W +: LANE_W] + b_i[gi*LANE_W +: LANE_W];
        end
    endgenerate

endmodule

// File: rtl/add_i8v4_arbiter.sv
// Round-robin arbiter feeding one shared lane adder into a single result slot,
// with per-requester delivery counters.
module add_i8v4_arbiter
    import add_i8v4_arbiter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [31:0]       in0_a,
    input  logic [31:0]       in0_b,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [31:0]       in1_a,
    input  logic [31:0]       in1_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_y,
    output logic              out_id,
    output logic [CNT_W-1:0]  done0_count,
    output logic [CNT_W-1:0]  done1_count
);

    slot_state_e      state_q, state_d;
    word_t            y_q, y_d;
    req_id_t          id_q, id_d;
    req_id_t          last_q, last_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    req_id_t grant;
    word_t   op_a, op_b, sum;
    logic    slot_free, accept, deliver;

    // A lone valid requester always wins; under contention the one not served last wins.
    always_comb begin
        grant = ~last_q;
        if (in0_valid && !in1_valid) begin
            grant = 1'b0;
        end else if (in1_valid && !in0_valid) begin
            grant = 1'b1;
        end
    end

    assign op_a = grant ? in1_a : in0_a;
    assign op_b = grant ? in1_b : in0_b;

    add_i8v4_lanes u_lanes (
        .a_i (op_a),
        .b_i (op_b),
        .y_o (sum)
    );

    assign slot_free = (state_q == SLOT_EMPTY) || out_ready;
    assign in0_ready = !reset && slot_free && (grant == 1'b0);
    assign in1_ready = !reset && slot_free && (grant == 1'b1);
    assign accept    = (in0_valid && in0_ready) || (in1_valid && in1_ready);
    assign deliver   = (state_q == SLOT_FULL) && out_ready;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        id_d    = id_q;
        last_d  = last_q;
        if (accept) begin
            state_d = SLOT_FULL;
            y_d     = sum;
            id_d    = grant;
            last_d  = grant;
        end else if (deliver) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (deliver && (id_q == 1'b0)) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (deliver && (id_q == 1'b1)) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SLOT_EMPTY;
            y_q     <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign out_valid   = (state_q == SLOT_FULL);
    assign out_y       = y_q;
    assign out_id      = id_q;
    assign done0_count = cnt0_q;
    assign done1_count = cnt1_q;

endmodule

// File: tb/tb_add_i8v4_arbiter.sv
// Self-checking bench for add_i8v4_arbiter: vector table, directed corner
// sequences and random traffic against a transaction-level slot model.
module tb_add_i8v4_arbiter;

    localparam int CNT_W = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
    logic             in0_ready, in1_ready, out_valid, out_id;
    logic [31:0]      in0_a = '0, in0_b = '0, in1_a = '0, in1_b = '0, out_y;
    logic [CNT_W-1:0] done0_count, done1_count;

    add_i8v4_arbiter #(.CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .in0_valid   (in0_valid),
        .in0_ready   (in0_ready),
        .in0_a       (in0_a),
        .in0_b       (in0_b),
        .in1_valid   (in1_valid),
        .in1_ready   (in1_ready),
        .in1_a       (in1_a),
        .in1_b       (in1_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .out_id      (out_id),
        .done0_count (done0_count),
        .done1_count (done1_count)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference slot: what the consumer should see, plus round-robin memory.
    logic        m_valid;
    logic [31:0] m_y;
    logic        m_id;
    logic        m_last;
    int          m_cnt[2];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Carry-free lane sum using the SWAR masking identity.
    function automatic logic [31:0] lane_sum(input logic [31:0] a, input logic [31:0] b);
        return ((a & 32'h7F7F7F7F) + (b & 32'h7F7F7F7F)) ^ ((a ^ b) & 32'h80808080);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_y     = '0;
        m_id    = 1'b0;
        m_last  = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk({tag, ".out_y"}, out_y, m_y);
            chk({tag, ".out_id"}, 32'(out_id), 32'(m_id));
        end
        chk({tag, ".done0"}, 32'(done0_count), 32'(m_cnt[0]));
        chk({tag, ".done1"}, 32'(done1_count), 32'(m_cnt[1]));
    endtask

    // One clock of traffic; called and returns at posedge+1.
    task automatic step(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic v1, input logic [31:0] a1, input logic [31:0] b1,
                        input logic ordy, input string tag);
        logic free, g, deliver, accept;
        in0_valid = v0; in0_a = a0; in0_b = b0;
        in1_valid = v1; in1_a = a1; in1_b = b1;
        out_ready = ordy;
        @(negedge clock);
        check_outputs(tag);
        free = !m_valid || ordy;
        g = (v0 && v1) ? !m_last : v1;
        if (v0 || v1) begin
            chk({tag, ".in0_ready"}, 32'(in0_ready), 32'(free && !g));
            chk({tag, ".in1_ready"}, 32'(in1_ready), 32'(free && g));
        end
        @(posedge clock);
        deliver = m_valid && ordy;
        accept  = (v0 || v1) && free;
        if (deliver) m_cnt[m_id] = (m_cnt[m_id] + 1) % (1 << CNT_W);
        if (accept) begin
            m_valid = 1'b1;
            m_y     = g ? lane_sum(a1, b1) : lane_sum(a0, b0);
            m_id    = g;
            m_last  = g;
        end else if (deliver) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        model_reset();
        #1;
        chk("rst.in0_ready", 32'(in0_ready), 32'd0);
        chk("rst.in1_ready", 32'(in1_ready), 32'd0);
        chk("rst.out_y", out_y, 32'd0);
        chk("rst.out_id", 32'(out_id), 32'd0);
        check_outputs("rst");
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h010202FC, 32'h01000301, 32'h020205FD};
        vecs[1] = '{32'hFF7F00FF, 32'h01010001, 32'h00800000};
        vecs[2] = '{32'h80808080, 32'h80808080, 32'h00000000};
        vecs[3] = '{32'h12345678, 32'h11111111, 32'h23456789};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFEFEFEFE};
        vecs[5] = '{32'h7F7F7F7F, 32'h01010101, 32'h80808080};

        do_reset();

        // Lane table through requester 0, one result per cycle.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vecs[i].a, vecs[i].b, 1'b0, '0, '0, 1'b1, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.y", i), out_y, vecs[i].y);
            chk($sformatf("vec%0d.id", i), 32'(out_id), 32'd0);
            if (i == 0) begin
                step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, "vec0.drain");
                chk("vec0.done0", 32'(done0_count), 32'd1);
            end
        end
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, "drain");

        // Contention straight after reset: strict 0,1,0,1 alternation.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 32'(k), 32'h01010101, 1'b1, 32'(k * 3), 32'h02020202, 1'b1, $sformatf("cont%0d", k));
            chk($sformatf("cont%0d.id", k), 32'(out_id), 32'(k % 2));
            if (k % 2 == 0 && k > 0)
                chk($sformatf("cont%0d.eq", k), 32'(done0_count), 32'(done1_count));
        end

        // Backpressure with slot full, then release.
        begin
            logic [31:0] held_y;
            logic        held_id;
            held_y  = out_y;
            held_id = out_id;
            for (int k = 0; k < 3; k++) begin
                step(1'b1, 32'hA0A0A0A0, 32'h0A0A0A0A, 1'b1, 32'h50505050, 32'h05050505, 1'b0, $sformatf("bp%0d", k));
                chk($sformatf("bp%0d.y", k), out_y, held_y);
                chk($sformatf("bp%0d.id", k), 32'(out_id), 32'(held_id));
            end
            step(1'b1, 32'hA0A0A0A0, 32'h0A0A0A0A, 1'b1, 32'h50505050, 32'h05050505, 1'b1, "bp.release");
            chk("bp.release.valid", 32'(out_valid), 32'd1);
            chk("bp.release.id", 32'(out_id), 32'(!held_id));
        end

        // Reset while full and stalled.
        step(1'b1, 32'h11223344, 32'h01010101, 1'b0, '0, '0, 1'b0, "mid.fill");
        step(1'b1, 32'h11223344, 32'h01010101, 1'b1, '0, '0, 1'b0, "mid.hold");
        #2;
        do_reset();
        step(1'b1, 32'h01020304, 32'h10101010, 1'b1, 32'h55555555, 32'h11111111, 1'b1, "mid.first");
        chk("mid.first.id", 32'(out_id), 32'd0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, "mid.drain");

        // Counter wrap: five deliveries from requester 1 on a 2-bit counter.
        do_reset();
        for (int k = 0; k < 5; k++)
            step(1'b0, '0, '0, 1'b1, 32'(k), 32'(k), 1'b1, $sformatf("wrap%0d", k));
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, "wrap.drain");
        chk("wrap.done1", 32'(done1_count), 32'd1);
        chk("wrap.done0", 32'(done0_count), 32'd0);

        // Random traffic.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 9) < 7), $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
